serial_subtractor: RTL



---
 rtl/serial_subtractor_pkg.sv | 15 +
 rtl/serial_subtractor_fa_cell.sv | 22 ++
 rtl/serial_subtractor.sv | 115 +++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor: FSM state encodings
// and the default operand width used when the parent is not overridden.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Encodings are fixed so that other blocks decoding the state agree
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_subtractor_fa_cell.sv
// serial_fa_cell
// Combinational 1-bit full adder, the only arithmetic element of the
// serial subtractor datapath.
// Ports:
//   a, b  : addend bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out (majority of a, b, cin)
module serial_fa_cell
  import serial_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial two's-complement subtractor computing diff = a - b - bin,
// one bit per clock, LSB first. A single full-adder cell is reused every
// cycle with the subtrahend bit inverted and the carry seeded with ~bin,
// so a - b - bin becomes a + ~b + ~bin.
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request pulse, accepted in IDLE or DONE
//   a, b   : minuend / subtrahend, latched when start is accepted
//   bin    : borrow in, latched with a and b
//   busy   : high while bits are being shifted
//   done   : one-cycle pulse when diff/bout are valid
//   diff   : result modulo 2^WIDTH, held until the next accepted start
//   bout   : borrow out, 1 when unsigned a < b + bin
//   ovf    : signed overflow (only with SUB_OVERFLOW_FLAG_EN defined)
// Optional feature macro: SUB_OVERFLOW_FLAG_EN
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic             carry;
  logic [CW-1:0]    count;
  logic             bnot;
  logic             fas;
  logic             facout;

  assign bnot = ~breg[0];

  serial_fa_cell u_fa (
    .a    (areg[0]),
    .b    (bnot),
    .cin  (carry),
    .s    (fas),
    .cout (facout)
  );

  // Controller and datapath registers. The operand registers shift right
  // each SHIFT cycle so the bit under processing is always at index 0;
  // on the final step index 0 therefore holds the original MSBs, which is
  // what the overflow flag needs without any extra tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      areg  <= '0;
      breg  <= '0;
      carry <= 1'b0;
      count <= '0;
`ifdef SUB_OVERFLOW_FLAG_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            areg  <= a;
            breg  <= b;
            carry <= ~bin;
            count <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          diff  <= {fas, diff[WIDTH-1:1]};
          carry <= facout;
          areg  <= areg >> 1;
          breg  <= breg >> 1;
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            bout  <= ~facout;
`ifdef SUB_OVERFLOW_FLAG_EN
            ovf   <= (areg[0] != breg[0]) && (fas != areg[0]);
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
